uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  UART receive stage: the downstream consumer of the transmitter's tx line.
//  Deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an async rx pin.
//  Presents each byte on DataOUT with a one-cycle valid strobe, or flags a framing error.
//  Sits between the pad and the byte-level consumer logic.
// PARAMETERS
//  CLKS_PER_BIT  16  CLK cycles per bit period (N). Even, >= 4; H = N/2.
// PORTS
//  CLK        in   1  system clock, rising-edge
//  Reset      in   1  synchronous, active-high reset
//  EN         in   1  receiver enable; gates start-bit detection only
//  rx         in   1  serial input, idle high, asynchronous to CLK
//  DataOUT    out  8  last good received byte, held until the next good byte
//  valid      out  1  one-cycle strobe: DataOUT updated this cycle
//  frame_err  out  1  one-cycle strobe: stop bit sampled low, byte discarded
//  busy       out  1  high whenever the state is not IDLE
// BEHAVIOUR
//  Reset values: DataOUT=0, valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
//   sync1, sync2 and rx_prev all reset to 1 (line idle).
//  Input sync: rx -> sync1 -> sync2 (rx_s). rx_prev <= rx_s every cycle.
//  State machine: IDLE, START, DATA, STOP. cnt = bit-period counter; bidx = 0..7.
//  - IDLE
//     Start condition: EN && rx_s==0 && rx_prev==1 (falling edge only).
//     On start: go to START, cnt=0.
//     A line held low never retriggers.
//  - START
//     cnt++ each cycle.
//     At cnt==H-1, sample rx_s:
//       0 -> DATA, cnt=0, bidx=0.
//       1 -> IDLE (glitch rejected; no strobe).
//  - DATA
//     cnt++ each cycle.
//     At cnt==N-1: shift rx_s into shreg[7] (shift right, LSB first), cnt=0, bidx++.
//     After bidx==7 is sampled -> STOP.
//  - STOP
//     At cnt==N-1, sample rx_s, then go to IDLE:
//       1 -> DataOUT<=shreg, valid=1.
//       0 -> frame_err=1, DataOUT unchanged.
//  Strobes: valid and frame_err default to 0 every cycle; never both high together.
//  Timing: edge k=0 is the one that captures rx low into sync1.
//   Start detected at edge 2.
//   Data bit i sampled at edge 2+H+(i+1)*N.
//   Stop bit sampled, and valid/frame_err high, after edge 2+H+9N (N=16: edge 154).
//   This is mid-bit sampling.
//  busy: 1 from the START entry edge through the STOP sample edge; 0 in the strobe cycle.
//  EN deasserted mid-frame: the current frame completes normally.
//   No new start is accepted while EN=0.
//  Back-to-back frames: a falling edge on the cycle right after the STOP sample is accepted.
//   Stop-to-start edge needs only the 1-cycle IDLE visit.
//  Reset mid-frame: returns to IDLE next edge; the partial byte is lost; no strobe.
//  Break (rx held low >= 10 bits): exactly one frame_err.
//   After that, no activity until rx returns high and falls again.
// TESTING
//  1. rx frame 0xF0 at N=16 after Reset -> valid exactly once at edge 154,
//     DataOUT=0xF0, frame_err=0.
//  2. 0x55 then 0xA5, stop bit 1N long, no gap -> two valid strobes 160 cycles apart,
//     DataOUT 0x55 then 0xA5.
//  3. rx low glitch for 4 cycles, then high -> back to IDLE, busy drops after START,
//     no valid, no frame_err.
//  4. Frame 0x3C with stop bit driven 0 -> frame_err once, valid=0, DataOUT keeps 0xA5.
//  5. Reset pulsed at data bit 3, then frame 0x81 -> no strobe for the aborted frame,
//     then valid with DataOUT=0x81.
//  6. EN=0 during frame 0x12 -> no busy, no strobe. Then EN=1 with rx held low 20N
//     -> one frame_err, then idle until rx rises.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronised rx, mid-bit sampling, one-cycle
// valid / frame_err strobes. DataOUT holds the last good byte.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       EN,
  input  logic       rx,
  output logic [7:0] DataOUT,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic            r_sync1, r_sync2, r_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bidx;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_valid, r_ferr, r_busy;

  logic            w_rx_s;
  logic            w_fall;
  logic            w_cnt_half;
  logic            w_cnt_last;

  assign w_rx_s     = r_sync2;
  assign w_fall     = EN && !w_rx_s && r_prev;
  assign w_cnt_half = (r_cnt == HALF_M1);
  assign w_cnt_last = (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= w_rx_s;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        // Edge-triggered start so a line stuck low (break) cannot retrigger.
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_cnt_half) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bidx  <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            r_shreg <= {w_rx_s, r_shreg[7:1]};
            r_cnt   <= '0;
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_cnt_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (w_rx_s) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOUT   = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of whole frames plus hand-written
// glitch, mid-frame reset, EN-gating and break sequences.
module tb_uart_receiver;

  localparam int N = 16;

  logic       CLK;
  logic       Reset;
  logic       EN;
  logic       rx;
  logic [7:0] DataOUT;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .CLK(CLK), .Reset(Reset), .EN(EN), .rx(rx),
    .DataOUT(DataOUT), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor: counts only ever increase; tests look at deltas.
  int         n_valid = 0, n_ferr = 0, n_both = 0, n_busy = 0;
  int         last_v_cyc = 0, last_f_cyc = 0;
  always @(negedge CLK) begin
    if (valid)              begin n_valid++; last_v_cyc = cyc; end
    if (frame_err)          begin n_ferr++;  last_f_cyc = cyc; end
    if (valid && frame_err) n_both++;
    if (busy)               n_busy++;
  end

  int n_err = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sb);
    logic [9:0] bits;
    bits = {sb, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      idle(N);
    end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int v0, f0, b0, t0, prev_v;
    logic [9:0] pbits;

    vecs[0] = '{8'hF0, 1'b1, 20, 1, 0, 8'hF0};
    vecs[1] = '{8'h55, 1'b1,  0, 1, 0, 8'h55};
    vecs[2] = '{8'hA5, 1'b1, 20, 1, 0, 8'hA5};
    vecs[3] = '{8'h3C, 1'b0, 20, 0, 1, 8'hA5};

    Reset = 1'b1; EN = 1'b1; rx = 1'b1;
    idle(3);
    chk("reset DataOUT", DataOUT, 0);
    chk("reset valid", valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    Reset = 1'b0;
    idle(5);

    prev_v = 0;
    for (int i = 0; i < 4; i++) begin
      v0 = n_valid; f0 = n_ferr; b0 = n_busy; t0 = cyc;
      send_frame(vecs[i].data, vecs[i].stop);
      chk($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d ferr count", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d DataOUT", i), DataOUT, vecs[i].exp_dout);
      chk($sformatf("vec%0d busy idle", i), busy, 0);
      chk($sformatf("vec%0d busy cycles", i), n_busy - b0, 152);
      if (vecs[i].exp_valid == 1)
        chk($sformatf("vec%0d strobe edge", i), last_v_cyc - t0, 155);
      else
        chk($sformatf("vec%0d strobe edge", i), last_f_cyc - t0, 155);
      if (i == 2) chk("back-to-back spacing", last_v_cyc - prev_v, 160);
      prev_v = last_v_cyc;
      idle(vecs[i].gap);
    end

    // Short low glitch: START rejects it at the half-bit sample.
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    idle(4);
    chk("glitch busy in START", busy, 1);
    rx = 1'b1;
    idle(8);
    chk("glitch busy dropped", busy, 0);
    idle(30);
    chk("glitch no valid", n_valid - v0, 0);
    chk("glitch no ferr", n_ferr - f0, 0);

    // Reset in the middle of data bit 3 of 0x81, then a clean 0x81.
    v0 = n_valid; f0 = n_ferr;
    pbits = {1'b1, 8'h81, 1'b0};
    for (int b = 0; b < 4; b++) begin rx = pbits[b]; idle(N); end
    rx = pbits[4];
    idle(N / 2);
    chk("abort busy before reset", busy, 1);
    Reset = 1'b1; rx = 1'b1;
    idle(1);
    Reset = 1'b0;
    chk("abort busy after reset", busy, 0);
    chk("abort DataOUT cleared", DataOUT, 0);
    idle(12 * N);
    chk("abort no valid", n_valid - v0, 0);
    chk("abort no ferr", n_ferr - f0, 0);
    t0 = cyc;
    send_frame(8'h81, 1'b1);
    chk("post-abort valid count", n_valid - v0, 1);
    chk("post-abort DataOUT", DataOUT, 8'h81);
    chk("post-abort strobe edge", last_v_cyc - t0, 155);
    idle(10);

    // EN low: whole frame ignored.
    EN = 1'b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    send_frame(8'h12, 1'b1);
    idle(10);
    chk("EN=0 no valid", n_valid - v0, 0);
    chk("EN=0 no ferr", n_ferr - f0, 0);
    chk("EN=0 never busy", n_busy - b0, 0);
    chk("EN=0 DataOUT kept", DataOUT, 8'h81);

    // Break: 20 bit times low gives one frame_err and no retrigger.
    EN = 1'b1;
    idle(5);
    b0 = n_busy; t0 = cyc;
    rx = 1'b0;
    idle(20 * N);
    chk("break ferr count", n_ferr - f0, 1);
    chk("break no valid", n_valid - v0, 0);
    chk("break ferr edge", last_f_cyc - t0, 155);
    chk("break busy cycles", n_busy - b0, 152);
    chk("break idle while low", busy, 0);
    rx = 1'b1;
    idle(3 * N);
    chk("break after rise ferr", n_ferr - f0, 1);
    chk("break after rise busy", n_busy - b0, 152);
    chk("break DataOUT kept", DataOUT, 8'h81);
    chk("valid and frame_err never together", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
